// File: rtl/jtag_cmd_axi_bridge.sv
// Turns one-cycle 128-bit register-style commands into single 2-beat, 64-bit AXI4 INCR bursts.
// Latency: the strobe reaches AW/AR after 1 cycle. One transaction is in flight at a time. Strobes that arrive while busy are dropped and reported.
module jtag_cmd_axi_bridge #(
    parameter logic AXI_ID = 1'b0
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         WrEn,
    input  logic [31:0]  WrAddr,
    input  logic [127:0] WrData,
    input  logic         RdEn,
    input  logic [31:0]  RdAddr,
    output logic [127:0] RdData,
    output logic         RdValid,
    output logic         Busy,
    output logic         Err,
    output logic         CmdDrop,
    output logic [31:0]  m_axi_awaddr,
    output logic [7:0]   m_axi_awlen,
    output logic [2:0]   m_axi_awsize,
    output logic [1:0]   m_axi_awburst,
    output logic         m_axi_awid,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [63:0]  m_axi_wdata,
    output logic [7:0]   m_axi_wstrb,
    output logic         m_axi_wlast,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bid,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [31:0]  m_axi_araddr,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic [1:0]   m_axi_arburst,
    output logic         m_axi_arid,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [63:0]  m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rid,
    input  logic         m_axi_rlast,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [31:0]   araddr_q, araddr_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          wlast_q, wlast_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   wr_hi_q, wr_hi_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          r_beat_q, r_beat_d;
    logic [63:0]   rd_lo_q, rd_lo_d;
    logic [127:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_pending_q, rd_pending_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          cmd_drop_q, cmd_drop_d;
    logic          aw_fin, w_fin;
    logic          unused_ok;

    // IDs are constant and only one burst is outstanding, so response IDs carry no information
    assign unused_ok = ^{m_axi_bid, m_axi_rid, WrAddr[3:0], RdAddr[3:0]};

    // A channel counts as finished once its valid has dropped or it is handshaking this cycle
    assign aw_fin = !awvalid_q || m_axi_awready;
    assign w_fin  = !wvalid_q || (m_axi_wready && wlast_q);

    always_comb begin
        state_d      = state_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        wlast_d      = wlast_q;
        wdata_d      = wdata_q;
        wr_hi_d      = wr_hi_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        r_beat_d     = r_beat_q;
        rd_lo_d      = rd_lo_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        rd_pending_d = rd_pending_q;
        err_d        = err_q;
        cmd_drop_d   = (state_q != S_IDLE) && (WrEn || RdEn);

        case (state_q)
            S_IDLE: begin
                if (WrEn) begin
                    awaddr_d  = {WrAddr[31:4], 4'h0};
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wdata_d   = WrData[63:0];
                    wr_hi_d   = WrData[127:64];
                    wlast_d   = 1'b0;
                    state_d   = S_WR;
                    if (RdEn) begin
                        araddr_d     = {RdAddr[31:4], 4'h0};
                        rd_pending_d = 1'b1;
                    end
                end else if (RdEn) begin
                    araddr_d  = {RdAddr[31:4], 4'h0};
                    arvalid_d = 1'b1;
                    state_d   = S_RD_ADDR;
                end
            end

            S_WR: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                    end else begin
                        wdata_d = wr_hi_q;
                        wlast_d = 1'b1;
                    end
                end
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (rd_pending_q) begin
                        rd_pending_d = 1'b0;
                        arvalid_d    = 1'b1;
                        state_d      = S_RD_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_beat_d  = 1'b0;
                    state_d   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                // Exactly two beats are consumed regardless of rlast, so a bad slave cannot wedge us
                if (m_axi_rvalid && rready_q) begin
                    if (!r_beat_q) begin
                        rd_lo_d  = m_axi_rdata;
                        r_beat_d = 1'b1;
                        if ((m_axi_rresp != 2'b00) || m_axi_rlast) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        rd_data_d  = {m_axi_rdata, rd_lo_q};
                        rd_valid_d = 1'b1;
                        rready_d   = 1'b0;
                        r_beat_d   = 1'b0;
                        state_d    = S_IDLE;
                        if ((m_axi_rresp != 2'b00) || !m_axi_rlast) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) || rd_pending_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            wdata_q      <= '0;
            wr_hi_q      <= '0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            r_beat_q     <= 1'b0;
            rd_lo_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_pending_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cmd_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            wlast_q      <= wlast_d;
            wdata_q      <= wdata_d;
            wr_hi_q      <= wr_hi_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            r_beat_q     <= r_beat_d;
            rd_lo_q      <= rd_lo_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_pending_q <= rd_pending_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            cmd_drop_q   <= cmd_drop_d;
        end
    end

    assign RdData        = rd_data_q;
    assign RdValid       = rd_valid_q;
    assign Busy          = busy_q;
    assign Err           = err_q;
    assign CmdDrop       = cmd_drop_q;

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'd1;
    assign m_axi_awsize  = 3'd3;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 8'hFF;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'd1;
    assign m_axi_arsize  = 3'd3;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = AXI_ID;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
